// File: rtl/spi_shift_engine.sv
// spi_shift_engine: serial data engine for the SPI master.
// Consumes the clock generator's pos_edge/neg_edge strobes. It shifts a
// latched word out on mosi and samples the serial input on the mode-correct
// SCK edges. It counts edges to end the transfer. busy/last_clk feed back
// into the clock generator so SCK stops cleanly after the final bit.
// Optional build macro: SPI_LOOPBACK_EN. When it is defined, mosi is sampled
// instead of miso, which gives an internal loopback for self-test.
module spi_shift_engine #(
  parameter int C_LEN_WIDTH = 5,
  localparam int C_DW = 2 ** C_LEN_WIDTH
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   lsb_first,
  input  logic [C_LEN_WIDTH-1:0] char_len,
  input  logic [C_DW-1:0]        tx_data,
  input  logic                   pos_edge,
  input  logic                   neg_edge,
  input  logic                   miso,
  output logic                   mosi,
  output logic [C_DW-1:0]        rx_data,
  output logic                   busy,
  output logic                   last_clk,
  output logic                   done
);

  // len and the bit index need one extra bit so that C_DW itself fits.
  // The edge counter needs two extra bits so that 2*C_DW fits.
  typedef logic [C_LEN_WIDTH-1:0] pos_t;
  typedef logic [C_LEN_WIDTH:0]   len_t;
  typedef logic [C_LEN_WIDTH+1:0] cnt_t;

  localparam len_t LEN_ONE = len_t'(1);
  localparam len_t LEN_MAX = len_t'(C_DW);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  state_t          next_state;

  // Transfer configuration, captured at go
  len_t            len_r;
  logic [C_DW-1:0] tx_r;
  logic            lsb_r;
  logic            cpol_r;
  logic            cpha_r;

  // Shift progress
  cnt_t            edge_cnt;
  len_t            bit_k;
  logic            sampled;
  logic [C_DW-1:0] rx_shift;

  // Decoded strobes and helpers
  logic            in_shift;
  logic            any_edge;
  logic            leading;
  logic            trailing;
  logic            sample_edge;
  logic            drive_edge;
  logic            advance;
  logic            final_edge;
  logic            pen_edge;
  logic            sample_in;
  cnt_t            cnt_inc;
  cnt_t            edge_total;
  len_t            len_in;
  pos_t            first_pos;
  pos_t            cur_pos;
  pos_t            next_pos;
  logic [C_DW-1:0] rx_next;

  logic            busy_next;
  logic            done_next;
  logic            last_next;

  // Map transfer bit index k to a word position: k for LSB-first and
  // len-1-k for MSB-first. k < len always holds, so truncation is safe.
  function automatic pos_t bit_pos(input len_t k, input len_t n, input logic lsb);
    return pos_t'(lsb ? k : (n - k - LEN_ONE));
  endfunction

`ifdef SPI_LOOPBACK_EN
  // Loopback: the receive path sees our own transmit bit; the pin is ignored.
  logic unused_miso;
  assign unused_miso = miso;
  assign sample_in   = mosi;
`else
  assign sample_in   = miso;
`endif

  assign in_shift    = (state == SHIFT);
  assign any_edge    = pos_edge | neg_edge;
  assign leading     = cpol_r ? neg_edge : pos_edge;
  assign trailing    = cpol_r ? pos_edge : neg_edge;
  assign sample_edge = cpha_r ? trailing : leading;
  assign drive_edge  = cpha_r ? leading  : trailing;

  assign cnt_inc     = edge_cnt + CNT_ONE;
  assign edge_total  = {len_r, 1'b0};
  assign final_edge  = in_shift & any_edge & (cnt_inc == edge_total);
  assign pen_edge    = in_shift & any_edge & (cnt_inc == (edge_total - CNT_ONE));

  // The final edge never advances mosi, so it keeps its last driven bit in IDLE.
  assign advance     = in_shift & drive_edge & sampled & ~final_edge;

  assign len_in      = (char_len == '0) ? LEN_MAX : {1'b0, char_len};
  assign first_pos   = bit_pos('0, len_in, lsb_first);
  assign cur_pos     = bit_pos(bit_k, len_r, lsb_r);
  assign next_pos    = bit_pos(bit_k + LEN_ONE, len_r, lsb_r);

  // Merge this cycle's sample so that rx_data can take it on the final edge (cpha=1)
  always_comb begin
    rx_next = rx_shift;
    if (in_shift && sample_edge) begin
      rx_next[cur_pos] = sample_in;
    end
  end

  // FSM state register
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: go starts a transfer, the 2*len-th edge ends it
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go)         next_state = SHIFT;
      SHIFT:   if (final_edge) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // FSM outputs: next values for the registered control outputs
  always_comb begin
    busy_next = (next_state == SHIFT);
    done_next = final_edge;
    last_next = last_clk;
    if (state == IDLE || final_edge) begin
      last_next = 1'b0;
    end else if (pen_edge) begin
      last_next = 1'b1;
    end
  end

  // Registered control outputs
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      last_clk <= 1'b0;
    end else begin
      busy     <= busy_next;
      done     <= done_next;
      last_clk <= last_next;
    end
  end

  // Capture the transfer configuration once per accepted go
  always_ff @(posedge sysclk) begin
    if (rst_n && state == IDLE && go) begin
      len_r  <= len_in;
      tx_r   <= tx_data;
      lsb_r  <= lsb_first;
      cpol_r <= cpol;
      cpha_r <= cpha;
    end
  end

  // Edge counter, bit index and sampled flag; IDLE ignores edges
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_k    <= '0;
      sampled  <= 1'b0;
    end else if (state == IDLE) begin
      if (go) begin
        edge_cnt <= '0;
        bit_k    <= '0;
        sampled  <= 1'b0;
      end
    end else if (any_edge) begin
      edge_cnt <= cnt_inc;
      if (sample_edge) begin
        sampled <= 1'b1;
      end else if (advance) begin
        sampled <= 1'b0;
        bit_k   <= bit_k + LEN_ONE;
      end
    end
  end

  // Receive shift register, cleared at the start of each transfer
  always_ff @(posedge sysclk) begin
    if (rst_n && state == IDLE && go) begin
      rx_shift <= '0;
    end else if (in_shift) begin
      rx_shift <= rx_next;
    end
  end

  // mosi presents the current bit; rx_data updates only on the final edge
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      mosi    <= 1'b0;
      rx_data <= '0;
    end else begin
      if (state == IDLE) begin
        if (go) begin
          mosi <= tx_data[first_pos];
        end
      end else if (advance) begin
        mosi <= tx_r[next_pos];
      end
      if (final_edge) begin
        rx_data <= rx_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed bench for spi_shift_engine with a
// transfer-level reference model and a per-cycle output compare.
module tb_spi_shift_engine;

  localparam int LW = 5;
  localparam int DW = 32;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic          sysclk    = 1'b0;
  logic          rst_n     = 1'b0;
  logic          go        = 1'b0;
  logic          cpol      = 1'b0;
  logic          cpha      = 1'b0;
  logic          lsb_first = 1'b0;
  logic [LW-1:0] char_len  = '0;
  logic [DW-1:0] tx_data   = '0;
  logic          pos_edge  = 1'b0;
  logic          neg_edge  = 1'b0;
  logic          miso      = 1'b0;
  logic          mosi;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          last_clk;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  bit chk_en      = 1'b0;
  logic [31:0] mosi_seq = '0;

  // Reference model state
  bit            m_active = 1'b0;
  int            m_n      = 0;
  int            m_len    = 0;
  bit            m_lsb    = 1'b0;
  bit            m_cpha   = 1'b0;
  logic [DW-1:0] m_tx     = '0;
  logic [DW-1:0] m_acc    = '0;
  logic          m_mosi   = 1'b0;
  logic          m_busy   = 1'b0;
  logic          m_last   = 1'b0;
  logic          m_done   = 1'b0;
  logic [DW-1:0] m_rx     = '0;

  spi_shift_engine #(.C_LEN_WIDTH(LW)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .go        (go),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .char_len  (char_len),
    .tx_data   (tx_data),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .miso      (miso),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .busy      (busy),
    .last_clk  (last_clk),
    .done      (done)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int k);
    return m_lsb ? k : (m_len - 1 - k);
  endfunction

  // Model: after n edges of a len-bit transfer, edges alternate leading and
  // trailing. cpha=0 samples on the odd edges and cpha=1 on the even edges.
  // The bit on mosi is n/2 (cpha=0) or (n-1)/2 (cpha=1).
  task automatic model_step(input logic g, input logic p, input logic ng, input logic mi);
    int   k;
    logic cur;
    if (!rst_n) begin
      m_active = 1'b0; m_mosi = 1'b0; m_rx = '0;
      m_busy = 1'b0; m_last = 1'b0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (!m_active) begin
      if (g) begin
        m_active = 1'b1;
        m_len    = (char_len == '0) ? DW : int'(char_len);
        m_tx     = tx_data;
        m_lsb    = lsb_first;
        m_cpha   = cpha;
        m_n      = 0;
        m_acc    = '0;
        m_busy   = 1'b1;
        m_last   = 1'b0;
        m_mosi   = m_tx[pos_of(0)];
      end
    end else if (p || ng) begin
      cur = LOOPBACK ? m_mosi : mi;
      m_n++;
      if ((m_n % 2 == 1) == !m_cpha) begin
        k = (m_n - 1) / 2;
        m_acc[pos_of(k)] = cur;
      end
      if (m_n == 2 * m_len) begin
        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_last = 1'b0;
        m_rx = m_acc;
      end else begin
        if (m_n == 2 * m_len - 1) m_last = 1'b1;
        k = m_cpha ? (m_n - 1) / 2 : m_n / 2;
        m_mosi = m_tx[pos_of(k)];
      end
    end
  endtask

  // Compare every output against the model, away from the active edge
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("mosi",     DW'(mosi),     DW'(m_mosi));
      check("busy",     DW'(busy),     DW'(m_busy));
      check("last_clk", DW'(last_clk), DW'(m_last));
      check("done",     DW'(done),     DW'(m_done));
      check("rx_data",  rx_data,       m_rx);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick(input logic g, input logic p, input logic n);
    go = g; pos_edge = p; neg_edge = n;
    @(posedge sysclk);
    #1;
    model_step(g, p, n, miso);
    go = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;
  endtask

  // One transfer: go, then 2*len edges with one gap cycle before each.
  // go_after/rst_after inject a second go or a reset before edge N+1.
  task automatic run_xfer(input logic cp, input logic ch, input logic lsb,
                          input logic [LW-1:0] clen, input logic [DW-1:0] tx,
                          input logic [DW-1:0] mw, input int go_after,
                          input int rst_after, input logic go_edge, input int trail);
    int   len;
    int   kk;
    logic sck;
    cpol = cp; cpha = ch; lsb_first = lsb; char_len = clen; tx_data = tx;
    len = (clen == '0) ? DW : int'(clen);
    sck = cp;
    mosi_seq = '0;
    tick(1'b1, go_edge, 1'b0);
    check("first_bit", DW'(mosi), DW'(tx[lsb ? 0 : len - 1]));
    for (int e = 1; e <= 2 * len; e++) begin
      if (rst_after > 0 && e - 1 == rst_after) begin
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("rst_mosi", DW'(mosi), 32'd0);
        check("rst_busy", DW'(busy), 32'd0);
        check("rst_last", DW'(last_clk), 32'd0);
        check("rst_done", DW'(done), 32'd0);
        check("rst_rx",   rx_data, 32'd0);
      end
      if (go_after > 0 && e - 1 == go_after) begin
        char_len = 5'd4;
        tx_data  = ~tx;
        tick(1'b1, 1'b0, 1'b0);
      end else begin
        tick(1'b0, 1'b0, 1'b0);
      end
      kk   = (e - 1) / 2;
      miso = mw[lsb ? kk : len - 1 - kk];
      if ((e % 2 == 1) == !ch) mosi_seq = {mosi_seq[30:0], mosi};
      tick(1'b0, ~sck, sck);
      sck = ~sck;
      if (rst_after == 0) begin
        if (e == 2 * len - 1) check("last_clk_pin", DW'(last_clk), 32'd1);
        if (e == 2 * len) begin
          check("done_pin", DW'(done), 32'd1);
          check("busy_end_pin", DW'(busy), 32'd0);
        end
        if (go_after > 0 && e == 8) check("busy_ignore_go", DW'(busy), 32'd1);
      end
    end
    repeat (trail) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("reset_mosi", DW'(mosi), 32'd0);
    check("reset_busy", DW'(busy), 32'd0);
    check("reset_rx",   rx_data,   32'd0);
    rst_n = 1'b1;
    // Edges in IDLE are ignored
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);

    // Mode 0, MSB-first, 8 bits; the next go lands in the done cycle
    run_xfer(1'b0, 1'b0, 1'b0, 5'd8, 32'hA5, 32'h3C, 0, 0, 1'b0, 0);
    check("rx_mode0", rx_data, LOOPBACK ? 32'hA5 : 32'h3C);
    check("mosi_seq_mode0", mosi_seq, 32'hA5);

    // Mode 3, LSB-first: the first leading edge must not advance mosi
    run_xfer(1'b1, 1'b1, 1'b1, 5'd8, 32'h01, 32'h96, 0, 0, 1'b0, 2);
    check("rx_mode3", rx_data, LOOPBACK ? 32'h01 : 32'h96);
    check("mosi_seq_mode3", mosi_seq, 32'h80);

    // char_len 0 is a full 32-bit word, 64 edges
    run_xfer(1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1'b0, 2);
    check("rx_full", rx_data, 32'hDEADBEEF);

    // char_len 1, mode 1: exactly two edges
    run_xfer(1'b0, 1'b1, 1'b0, 5'd1, 32'h1, 32'h0, 0, 0, 1'b0, 2);
    check("rx_len1", rx_data, LOOPBACK ? 32'h1 : 32'h0);

    // Mode 2 with a second go and a rewritten char_len mid-transfer
    run_xfer(1'b1, 1'b0, 1'b0, 5'd8, 32'h5A, 32'hC3, 6, 0, 1'b0, 2);
    check("rx_go_ignored", rx_data, LOOPBACK ? 32'h5A : 32'hC3);

    // Reset after 5 edges; the remaining edges are ignored
    run_xfer(1'b0, 1'b0, 1'b0, 5'd8, 32'hFF, 32'h00, 0, 5, 1'b0, 2);
    check("busy_after_abort", DW'(busy), 32'd0);

    // Clean transfer after reset; go shares its cycle with an ignored edge
    run_xfer(1'b0, 1'b1, 1'b1, 5'd12, 32'hABC, 32'h123, 0, 0, 1'b1, 3);
    check("rx_after_reset", rx_data, LOOPBACK ? 32'hABC : 32'h123);

    check("done_count", DW'(done_cnt), 32'd6);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Serial data engine for the SPI master. It sits directly downstream of the SPI clock generator and consumes that block's pos_edge/neg_edge strobes. It loads a parallel word, drives MOSI, samples MISO on the mode-correct edges and counts edges to end the transfer. Its busy and last_clk outputs drive the clock generator's enable and last_clk inputs, so the generator stops cleanly after the final bit.

## Interface
- C_LEN_WIDTH, 5, width of the char-length field; data width C_DW = 2**C_LEN_WIDTH (default 32)
- sysclk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- go  in  1  start pulse; accepted only in IDLE
- cpol  in  1  clock polarity (idle level of SCK)
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- lsb_first  in  1  1 = bit 0 transmitted first
- char_len  in  C_LEN_WIDTH  bits per transfer; 0 means C_DW
- tx_data  in  C_DW  word to send, right-justified
- pos_edge  in  1  rising-SCK strobe from the clock generator
- neg_edge  in  1  falling-SCK strobe from the clock generator
- miso  in  1  serial input
- mosi  out  1  serial output
- rx_data  out  C_DW  received word, right-justified, upper bits zero
- busy  out  1  transfer in progress; feeds the clock generator enable
- last_clk  out  1  final SCK edge pending; feeds the clock generator last_clk
- done  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, SHIFT.
- IDLE → SHIFT on go:
  - latch char_len as len (0 → C_DW), tx_data, lsb_first, cpol, cpha;
  - clear edge_cnt, the sampled flag and the rx shift register.
- Edge selection:
  - leading = cpol ? neg_edge : pos_edge; trailing = the other strobe.
  - sample_edge = cpha ? trailing : leading.
  - drive_edge = cpha ? leading : trailing.
- In SHIFT, every pos_edge or neg_edge increments edge_cnt. edge_cnt is C_LEN_WIDTH+2 bits wide, so 2*C_DW never overflows.
- sample_edge: capture miso into bit k of the received word, where k is the transfer bit index, 0 for the first bit. The bit lands at position len-1-k (MSB-first) or k (LSB-first). Set sampled.
- drive_edge with sampled = 1: advance mosi to the next bit and clear sampled. A drive_edge with sampled = 0 is ignored, which covers the first leading edge in cpha = 1.
- mosi in SHIFT is always the current bit: tx_data[len-1-k] (MSB-first) or tx_data[k] (LSB-first).
- The transfer ends on the edge that makes edge_cnt = 2*len. On that edge:
  - return to IDLE;
  - update rx_data;
  - pulse done.
- Boundaries:
  - go while busy: ignored.
  - Edges in IDLE: ignored.
  - go and an edge in the same cycle in IDLE: the edge is ignored.
  - char_len/tx_data changes during SHIFT: no effect.
- Reset at any time, including mid-transfer: all outputs return to reset values on the next sysclk edge and the state returns to IDLE.

## Timing
- Reset values: mosi = 0, rx_data = 0, busy = 0, last_clk = 0, done = 0.
- go sampled at cycle N → busy = 1 and mosi = first bit at N+1.
  - cpha = 0: the first bit is valid before the first SCK edge.
- All outputs are registered.
  - An edge strobe in cycle M updates mosi and the internal rx register at M+1.
- last_clk = 1 from the cycle after the (2*len-1)th edge until busy falls.
- Final (2*len)th edge in cycle M:
  - done = 1 and busy = 0 at M+1;
  - rx_data valid from M+1 and held until the next transfer ends;
  - done lasts exactly one cycle.
- In IDLE, mosi holds its last driven value (0 after reset).
- A new go is accepted in the cycle done is high.

## Configuration
- SPI_LOOPBACK_EN:
  - Defined: the sampled input is mosi instead of miso, giving internal loopback for self-test; the miso pin is ignored.
  - Undefined: miso is sampled as described; no loopback logic is present.

## Test plan
- Mode 0 (cpol = 0, cpha = 0), MSB-first, char_len = 8, tx_data = 0xA5, miso driven with 0x3C → mosi sequence 1,0,1,0,0,1,0,1; rx_data = 0x3C; 16 edges; one done pulse.
- Mode 3 (cpol = 1, cpha = 1), LSB-first, char_len = 8, tx_data = 0x01 → mosi = 1 then seven 0s; the first leading edge does not advance mosi.
- char_len = 0, tx_data = 0xDEADBEEF, loopback (SPI_LOOPBACK_EN) → 64 edges; rx_data = 0xDEADBEEF.
- char_len = 1, mode 1 → exactly 2 edges; last_clk high after edge 1; done one cycle after edge 2.
- Second go mid-transfer, char_len rewritten to 4 → ignored; transfer completes with the original 8 bits.
- rst_n low after 5 edges → outputs at reset values next cycle; following edges ignored; a new go starts a clean transfer.
